// File: rtl/counter_pkg.sv
// counter_pkg: shared constants and helpers for the BCD up/down counter.
//   - BCD nibble and seven-segment field widths
//   - active-high seven-segment patterns, bit order {g,f,e,d,c,b,a}
//   - per-digit register operation encoding
//   - seg_decode(): BCD nibble to segment pattern; non-BCD values go blank
package counter_pkg;

    localparam int unsigned BCD_W = 4;
    localparam int unsigned SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

    // What a digit register does on the coming edge, in priority order.
    typedef enum logic [2:0] {
        DIG_HOLD,
        DIG_CLEAR,
        DIG_LOAD,
        DIG_INC,
        DIG_DEC
    } digit_op_e;

    function automatic logic [SEG_W-1:0] seg_decode(input logic [BCD_W-1:0] d);
        logic [SEG_W-1:0] seg;
        case (d)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bcd_updown_counter_digit.sv
// bcd_digit: one decimal digit of the BCD up/down counter.
// Ports:
//   clk      - rising-edge clock
//   reset    - synchronous active-high clear
//   load     - synchronous load of load_nib (A-F load as 0), beats cen
//   load_nib - BCD nibble to load
//   cen      - carry-in enable: step this digit on the coming edge
//   up       - direction of the step (1 = increment, 0 = decrement)
//   digit    - registered digit value (always 0-9)
//   at9      - digit is 9 (carry condition for the next digit when counting up)
//   at0      - digit is 0 (borrow condition for the next digit when counting down)
module bcd_digit
    import counter_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [BCD_W-1:0] load_nib,
    input  logic             cen,
    input  logic             up,
    output logic [BCD_W-1:0] digit,
    output logic             at9,
    output logic             at0
);

    digit_op_e        op;
    logic [BCD_W-1:0] digit_d;
    logic [BCD_W-1:0] digit_q;

    always_comb begin
        if (reset) begin
            op = DIG_CLEAR;
        end else if (load) begin
            op = DIG_LOAD;
        end else if (cen) begin
            op = up ? DIG_INC : DIG_DEC;
        end else begin
            op = DIG_HOLD;
        end
    end

    always_comb begin
        digit_d = digit_q;
        case (op)
            DIG_CLEAR: digit_d = '0;
            DIG_LOAD:  digit_d = (load_nib > 4'd9) ? '0 : load_nib;
            DIG_INC:   digit_d = (digit_q >= 4'd9) ? '0 : digit_q + 4'd1;
            DIG_DEC:   digit_d = (digit_q == 4'd0) ? 4'd9 : digit_q - 4'd1;
            default:   digit_d = digit_q;
        endcase
    end

    always_ff @(posedge clk) begin
        digit_q <= digit_d;
    end

    assign digit = digit_q;
    assign at9   = (digit_q == 4'd9);
    assign at0   = (digit_q == 4'd0);

endmodule

// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter: DIGITS-digit synchronous BCD up/down counter with
// per-digit seven-segment drive and a cascadable terminal count.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zero digits
// (digit 0 is never blanked); count and tc are unaffected by it.
// Ports:
//   clk      - rising-edge clock
//   reset    - synchronous active-high reset (count = 0)
//   en       - count enable, one step per clock
//   up       - direction, 1 = up, 0 = down
//   load     - synchronous parallel load, beats en
//   load_val - BCD load value, digit i at [4i+3:4i]
//   count    - registered BCD count, digit 0 least significant
//   dout     - segment patterns, digit i at [7i+6:7i], {g,f,e,d,c,b,a}
//   tc       - terminal count (all-9s up / all-0s down), qualified by
//              en && !load && !reset; feeds en of a further counter
module bcd_updown_counter
    import counter_pkg::*;
#(
    parameter int unsigned DIGITS = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    up,
    input  logic                    load,
    input  logic [BCD_W*DIGITS-1:0] load_val,
    output logic [BCD_W*DIGITS-1:0] count,
    output logic [SEG_W*DIGITS-1:0] dout,
    output logic                    tc
);

    logic [DIGITS-1:0] cen;
    logic [DIGITS-1:0] at9;
    logic [DIGITS-1:0] at0;
    logic              carry_out;

    // Ripple the step enable up the digits: digit i steps when every lower
    // digit is at its wrap value for the current direction. The value left
    // after the top digit is "whole counter at its wrap value and enabled".
    always_comb begin
        logic carry;
        carry = en;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            cen[i] = carry;
            carry  = carry & (up ? at9[i] : at0[i]);
        end
        carry_out = carry;
    end

    assign tc = carry_out & ~load & ~reset;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_digit
            bcd_digit u_digit (
                .clk      (clk),
                .reset    (reset),
                .load     (load),
                .load_nib (load_val[BCD_W*g +: BCD_W]),
                .cen      (cen[g]),
                .up       (up),
                .digit    (count[BCD_W*g +: BCD_W]),
                .at9      (at9[g]),
                .at0      (at0[g])
            );
        end
    endgenerate

    always_comb begin
        for (int unsigned i = 0; i < DIGITS; i++) begin
            dout[SEG_W*i +: SEG_W] = seg_decode(count[BCD_W*i +: BCD_W]);
        end
`ifdef LEADING_ZERO_BLANK_EN
        // Walk from the most significant digit down while everything seen
        // so far is zero; those digits go blank, except digit 0.
        begin
            logic        all_zero;
            int unsigned idx;
            all_zero = 1'b1;
            for (int unsigned k = 0; k < DIGITS; k++) begin
                idx      = DIGITS - 1 - k;
                all_zero = all_zero & at0[idx];
                if (all_zero && (idx != 0)) begin
                    dout[SEG_W*idx +: SEG_W] = SEG_BLANK;
                end
            end
        end
`endif
    end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// tb_bcd_updown_counter: directed self-checking bench for bcd_updown_counter.
// Instances: u_dut (DIGITS=2), u_cas_lo/u_cas_hi (DIGITS=1 cascade) against
// u_cas_ref (DIGITS=2), u_wide (DIGITS=4) for the display decode.
module tb_bcd_updown_counter;

    logic        clk;
    logic        reset;
    logic        en;
    logic        up;
    logic        load;
    logic [7:0]  load_val;
    logic [7:0]  count;
    logic [13:0] dout;
    logic        tc;

    logic        cas_reset;
    logic        cas_en;
    logic        cas_up;
    logic [3:0]  lo_count;
    logic [3:0]  hi_count;
    logic [6:0]  lo_dout;
    logic [6:0]  hi_dout;
    logic        lo_tc;
    logic        hi_tc;
    logic [7:0]  ref_count;
    logic [13:0] ref_dout;
    logic        ref_tc;

    logic        w_load;
    logic [15:0] w_val;
    logic [15:0] w_count;
    logic [27:0] w_dout;
    logic        w_tc;

    int checks;
    int errors;

    bcd_updown_counter #(.DIGITS(2)) u_dut (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(load_val), .count(count), .dout(dout), .tc(tc)
    );

    bcd_updown_counter #(.DIGITS(1)) u_cas_lo (
        .clk(clk), .reset(cas_reset), .en(cas_en), .up(cas_up), .load(1'b0),
        .load_val(4'h0), .count(lo_count), .dout(lo_dout), .tc(lo_tc)
    );

    bcd_updown_counter #(.DIGITS(1)) u_cas_hi (
        .clk(clk), .reset(cas_reset), .en(lo_tc), .up(cas_up), .load(1'b0),
        .load_val(4'h0), .count(hi_count), .dout(hi_dout), .tc(hi_tc)
    );

    bcd_updown_counter #(.DIGITS(2)) u_cas_ref (
        .clk(clk), .reset(cas_reset), .en(cas_en), .up(cas_up), .load(1'b0),
        .load_val(8'h00), .count(ref_count), .dout(ref_dout), .tc(ref_tc)
    );

    bcd_updown_counter #(.DIGITS(4)) u_wide (
        .clk(clk), .reset(reset), .en(1'b0), .up(1'b1), .load(w_load),
        .load_val(w_val), .count(w_count), .dout(w_dout), .tc(w_tc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] to_bcd2(input int n);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = 4'(n / 10);
        ones = 4'(n % 10);
        return {tens, ones};
    endfunction

    initial begin
        int m;
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        en        = 1'b1;
        up        = 1'b1;
        load      = 1'b0;
        load_val  = 8'h00;
        cas_reset = 1'b1;
        cas_en    = 1'b0;
        cas_up    = 1'b1;
        w_load    = 1'b0;
        w_val     = 16'h0000;

        // Reset state, with en high to show reset dominates tc
        tick();
        check_eq("reset_count", 32'(count), 32'h00);
        check_eq("reset_tc", 32'(tc), 32'h0);
`ifdef LEADING_ZERO_BLANK_EN
        check_eq("reset_dout", 32'(dout), 32'({7'h00, 7'h3F}));
`else
        check_eq("reset_dout", 32'(dout), 32'({7'h3F, 7'h3F}));
`endif

        // Count up 00..99 then wrap
        reset = 1'b0;
        for (int k = 0; k < 100; k++) begin
            #1;
            check_eq("up_count", 32'(count), 32'(to_bcd2(k)));
            check_eq("up_tc", 32'(tc), 32'(k == 99));
            if (k == 42) check_eq("dout_42", 32'(dout), 32'({7'h66, 7'h5B}));
            tick();
        end
        check_eq("up_wrap", 32'(count), 32'h00);

        // Count down from reset: 00 -> 99 -> 98 .. 90
        reset = 1'b1;
        tick();
        reset = 1'b0;
        up    = 1'b0;
        #1;
        check_eq("dn_tc_at_00", 32'(tc), 32'h1);
        tick();
        check_eq("dn_wrap", 32'(count), 32'h99);
        check_eq("dn_tc_at_99", 32'(tc), 32'h0);
        for (int j = 8; j >= 0; j--) begin
            tick();
            check_eq("dn_count", 32'(count), 32'({4'd9, 4'(j)}));
        end

        // Load beats en; non-BCD nibbles load as 0
        load     = 1'b1;
        load_val = 8'h37;
        #1;
        check_eq("load_tc", 32'(tc), 32'h0);
        tick();
        check_eq("load_37", 32'(count), 32'h37);
        load_val = 8'hA5;
        tick();
        check_eq("load_A5", 32'(count), 32'h05);
        load_val = 8'hF9;
        tick();
        check_eq("load_F9", 32'(count), 32'h09);

        // tc at 99 counting up is masked by load
        load_val = 8'h99;
        tick();
        up = 1'b1;
        #1;
        check_eq("tc_masked_load", 32'(tc), 32'h0);
        load = 1'b0;
        #1;
        check_eq("tc_99_up", 32'(tc), 32'h1);
        en = 1'b0;
        #1;
        check_eq("tc_no_en", 32'(tc), 32'h0);

        // Reach 58 by counting, then reset together with load
        load     = 1'b1;
        load_val = 8'h56;
        tick();
        load = 1'b0;
        en   = 1'b1;
        tick();
        tick();
        check_eq("count_58", 32'(count), 32'h58);
        reset    = 1'b1;
        load     = 1'b1;
        load_val = 8'h12;
        #1;
        check_eq("tc_in_reset", 32'(tc), 32'h0);
        tick();
        reset = 1'b0;
        load  = 1'b0;
        en    = 1'b0;
        #1;
        check_eq("reset_mid", 32'(count), 32'h00);
`ifdef LEADING_ZERO_BLANK_EN
        check_eq("reset_mid_dout", 32'(dout), 32'({7'h00, 7'h3F}));
`else
        check_eq("reset_mid_dout", 32'(dout), 32'({7'h3F, 7'h3F}));
`endif

        // Cascade of two single digits versus one two-digit counter
        tick();
        cas_reset = 1'b0;
        m = 0;
        for (int k = 0; k < 250; k++) begin
            cas_en = ($urandom_range(0, 3) != 0);
            cas_up = ($urandom_range(0, 1) != 0);
            #1;
            check_eq("cas_vs_ref", 32'({hi_count, lo_count}), 32'(ref_count));
            check_eq("cas_model", 32'(ref_count), 32'(to_bcd2(m)));
            check_eq("cas_tc", 32'(hi_tc), 32'(cas_en && (cas_up ? (m == 99) : (m == 0))));
            tick();
            if (cas_en) m = cas_up ? (m + 1) % 100 : (m + 99) % 100;
        end

        // Four-digit display decode of 0070
        w_load = 1'b1;
        w_val  = 16'h0070;
        tick();
        w_load = 1'b0;
        #1;
        check_eq("wide_count", 32'(w_count), 32'h0070);
`ifdef LEADING_ZERO_BLANK_EN
        check_eq("wide_dout", 32'(w_dout), 32'({7'h00, 7'h00, 7'h07, 7'h3F}));
`else
        check_eq("wide_dout", 32'(w_dout), 32'({7'h3F, 7'h3F, 7'h07, 7'h3F}));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_updown_counter.md
# bcd_updown_counter

Parametrised synchronous multi-digit BCD counter with a direct seven-segment drive for each digit. It extends the single-digit 0–15 counter-plus-decoder to:
- DIGITS decimal digits;
- up/down counting, count enable and synchronous parallel load;
- a cascadable terminal-count output.

It sits between the board clock/reset and the seven-segment display pins. The `tc` output can feed the `en` input of a further counter.

## Interface
- DIGITS, default 2: number of BCD digits. Legal range 1..4. Count range is 0 .. 10^DIGITS−1.
- clk  input  1  rising-edge clock; the block's only clock.
- reset  input  1  synchronous, active-high reset.
- en  input  1  count enable. When high, the counter advances one step per clock.
- up  input  1  direction. 1 counts up, 0 counts down. Sampled only when counting.
- load  input  1  synchronous parallel load; takes priority over `en`.
- load_val  input  4*DIGITS  BCD value to load. Digit i occupies bits [4i+3:4i].
- count  output  4*DIGITS  registered BCD count. Digit 0 is least significant.
- dout  output  7*DIGITS  seven-segment pattern. Digit i occupies bits [7i+6:7i], bit order {g,f,e,d,c,b,a}, active-high segments.
- tc  output  1  terminal count, combinational.

## Operation
- Priority at each rising edge of `clk`: `reset` > `load` > `en`. With none asserted, `count` holds.
- Reset: `count` = 0.
- Load:
  - each `load_val` nibble 0–9 is copied to the matching digit;
  - a nibble A–F loads that digit as 0.
- Count up, per digit: digit i increments only when `en` is high and all lower digits are 9. A digit at 9 that increments wraps to 0.
- Count down, per digit: digit i decrements only when `en` is high and all lower digits are 0. A digit at 0 that decrements wraps to 9.
- Full wrap: all-9s counting up goes to all-0s; all-0s counting down goes to all-9s.
- `tc`:
  - up && count == all-9s → `tc` = 1;
  - !up && count == all-0s → `tc` = 1;
  - otherwise `tc` = 0.
  - `tc` is additionally qualified by `en` && !`load` && !`reset`.
- `dout` is a combinational decode of `count`. Active-high patterns: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F.
- Non-BCD digit values cannot occur in `count`. The decoder maps them to 0x00 defensively.
- Changing `up` between cycles is legal. It takes effect on the next enabled edge.

## Timing
- `count` updates one clock after a qualifying edge; there is no pipeline.
- `dout` and `tc` follow `count` and the inputs in the same cycle: zero-latency combinational paths.
- Reset values:
  - `count` = 0;
  - `dout` = 0x3F on every digit (0x3F on digit 0 and 0x00 on higher digits when blanking is compiled in);
  - `tc` = 0 while `reset` is high.
- Reset asserted mid-count clears on the next edge, regardless of `load`/`en`.
- `load` and `en` high together: the load wins and `tc` is forced to 0 that cycle.
- Cascading: counter B with B.en = A.tc advances exactly on the edge where A wraps.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - for digit i > 0, `dout` for that digit is 0x00 when that digit and every more-significant digit are 0;
  - digit 0 is never blanked.
- LEADING_ZERO_BLANK_EN undefined: every digit always shows its decoded value.
- `count` and `tc` are identical in both builds.

## Structure
- Shared package `counter_pkg` holds:
  - the ten segment-pattern constants and the blank pattern 0x00;
  - the BCD nibble width constant (4) and segment width constant (7).
- Sub-module `bcd_digit`, instantiated DIGITS times in a generate loop. Each instance contains:
  - one 4-bit digit register;
  - inputs: carry-in enable, up, load nibble;
  - outputs: digit value, "at 9" and "at 0" flags for the next stage's carry chain.
- The seven-segment decode is a package function, not a separate module.

## Test plan
All scenarios use DIGITS=2 unless stated.
- Reset then `en`=1, `up`=1 for 100 clocks → count runs 00..99. On the last edge it wraps to 00. `tc`=1 only in the cycle when count=99. `dout` at 42 = {0x66, 0x5B}.
- `en`=1, `up`=0 starting from reset → first edge gives 99 and `tc`=1 in the cycle with count=00. Next 9 edges give 98..90.
- `load`=1, `load_val`=0x37, with `en`=1 in the same cycle → count=37 and `tc`=0 that cycle. Then `load_val`=0xA5 → count=05.
- Counting at 58, assert `reset` for one cycle together with `load` → count=00 and `dout`=0x3F3F (or 0x003F with LEADING_ZERO_BLANK_EN).
- Cascade two DIGITS=1 instances via `tc` → `en` and compare against one DIGITS=2 instance over 250 mixed up/down cycles → identical BCD counts.
- LEADING_ZERO_BLANK_EN build, DIGITS=4, load 0x0070 → `dout` digit 0 = 0x3F, digit 1 = 0x07, digits 2 and 3 = 0x00.
